// File: rtl/dma_lite_pkg.sv
// ---------------------------------------------------------------------------
// dma_lite_pkg
//   Shared definitions for the DMA-lite register-write arbiter:
//     - requester count, AXI-Lite address and data widths
//     - arbiter FSM state encoding
//     - other_req(): the requester that is not idx (two-requester fabric)
// ---------------------------------------------------------------------------
package dma_lite_pkg;

   localparam int N_REQ  = 2;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_e;

   // With exactly two requesters the "other" one is simply the inverse index.
   function automatic logic other_req(input logic idx);
      return ~idx;
   endfunction

endpackage

// File: rtl/lite_req_slot.sv
// ---------------------------------------------------------------------------
// lite_req_slot
//   One-entry request holding register for a single requester.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     valid_i     : one-cycle request pulse
//     addr_i      : request address, sampled with valid_i
//     data_i      : request data, sampled with valid_i
//     clear_i     : arbiter finished this slot's transaction this cycle
//     pending_o   : slot holds a request not yet completed
//     addr_o      : captured address
//     data_o      : captured data
//     ovf_o       : sticky, a request was dropped because the slot was full
// ---------------------------------------------------------------------------
module lite_req_slot
   import dma_lite_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              clear_i,
   output logic              pending_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   output logic              ovf_o
);

   logic              pending_q, pending_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ovf_q, ovf_d;

   always_comb begin
      pending_d = pending_q;
      addr_d    = addr_q;
      data_d    = data_q;
      ovf_d     = ovf_q;

      if (clear_i) begin
         pending_d = 1'b0;
      end

      // The slot is considered free in the cycle its transaction completes,
      // so a request arriving then is captured rather than flagged.
      if (valid_i) begin
         if (!pending_q || clear_i) begin
            pending_d = 1'b1;
            addr_d    = addr_i;
            data_d    = data_i;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         ovf_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         ovf_q     <= ovf_d;
      end
   end

   assign pending_o = pending_q;
   assign addr_o    = addr_q;
   assign data_o    = data_q;
   assign ovf_o     = ovf_q;

endmodule

// File: rtl/dma_lite_arb.sv
// ---------------------------------------------------------------------------
// dma_lite_arb
//   Round-robin arbiter sharing one AXI-Lite write engine between the MM2S
//   (requester 0) and S2MM (requester 1) control paths.
//   Parameter:
//     TIMEOUT_CYCLES : WAIT cycles without lite_end before a write is abandoned
//   Ports:
//     clk, rst                     : clock, synchronous active-high reset
//     reqN_valid/awaddr/wdata      : request pulse with address and data
//     reqN_end                     : one-cycle pulse, requester N finished
//     lite_valid/awaddr/wdata      : issue pulse and held address/data
//     lite_end                     : write response pulse from the engine
//     ovf_err[1:0]                 : sticky per-requester dropped-request flag
//     timeout_err                  : sticky, some transaction timed out
// ---------------------------------------------------------------------------
module dma_lite_arb
   import dma_lite_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_awaddr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_end,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_awaddr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_end,
   output logic              lite_valid,
   output logic [ADDR_W-1:0] lite_awaddr,
   output logic [DATA_W-1:0] lite_wdata,
   input  logic              lite_end,
   output logic [1:0]        ovf_err,
   output logic              timeout_err
);

   // Counter only has to reach TIMEOUT_CYCLES-1, so clog2 bits never wrap.
   localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   // ---------------------------------------------------------------------
   // Request slots
   // ---------------------------------------------------------------------
   logic [N_REQ-1:0]  req_valid;
   logic [ADDR_W-1:0] req_addr  [N_REQ];
   logic [DATA_W-1:0] req_data  [N_REQ];
   logic [N_REQ-1:0]  pending;
   logic [ADDR_W-1:0] slot_addr [N_REQ];
   logic [DATA_W-1:0] slot_data [N_REQ];
   logic [N_REQ-1:0]  slot_ovf;
   logic [N_REQ-1:0]  slot_clear;

   assign req_valid   = {req1_valid, req0_valid};
   assign req_addr[0] = req0_awaddr;
   assign req_addr[1] = req1_awaddr;
   assign req_data[0] = req0_wdata;
   assign req_data[1] = req1_wdata;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
      lite_req_slot u_slot (
         .clk       (clk),
         .rst       (rst),
         .valid_i   (req_valid[gi]),
         .addr_i    (req_addr[gi]),
         .data_i    (req_data[gi]),
         .clear_i   (slot_clear[gi]),
         .pending_o (pending[gi]),
         .addr_o    (slot_addr[gi]),
         .data_o    (slot_data[gi]),
         .ovf_o     (slot_ovf[gi])
      );
   end

   // ---------------------------------------------------------------------
   // Arbiter FSM: next-state / next-output logic
   // ---------------------------------------------------------------------
   arb_state_e        state_q, state_d;
   logic              rr_q, rr_d;
   logic              grant_q, grant_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              lite_valid_q, lite_valid_d;
   logic [ADDR_W-1:0] lite_awaddr_q, lite_awaddr_d;
   logic [DATA_W-1:0] lite_wdata_q, lite_wdata_d;
   logic [N_REQ-1:0]  req_end_q, req_end_d;
   logic              timeout_err_q, timeout_err_d;
   logic              grant_sel;
   logic              timed_out;

   always_comb begin
      state_d       = state_q;
      rr_d          = rr_q;
      grant_d       = grant_q;
      cnt_d         = cnt_q;
      lite_valid_d  = 1'b0;
      lite_awaddr_d = lite_awaddr_q;
      lite_wdata_d  = lite_wdata_q;
      req_end_d     = '0;
      timeout_err_d = timeout_err_q;
      slot_clear    = '0;
      timed_out     = 1'b0;

      // Round-robin: the pointed-to requester wins if it is waiting.
      grant_sel = pending[rr_q] ? rr_q : other_req(rr_q);

      case (state_q)
         ST_IDLE: begin
            if (|pending) begin
               grant_d       = grant_sel;
               lite_valid_d  = 1'b1;
               lite_awaddr_d = slot_addr[grant_sel];
               lite_wdata_d  = slot_data[grant_sel];
               state_d       = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            // lite_end is deliberately not looked at here.
            cnt_d   = '0;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            timed_out = (cnt_q == CNT_LAST);
            if (lite_end || timed_out) begin
               slot_clear[grant_q] = 1'b1;
               req_end_d[grant_q]  = 1'b1;
               rr_d                = other_req(grant_q);
               cnt_d               = '0;
               state_d             = ST_IDLE;
               // A response landing on the last cycle is a normal completion.
               if (!lite_end) begin
                  timeout_err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         rr_q          <= 1'b0;
         grant_q       <= 1'b0;
         cnt_q         <= '0;
         lite_valid_q  <= 1'b0;
         lite_awaddr_q <= '0;
         lite_wdata_q  <= '0;
         req_end_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_q          <= rr_d;
         grant_q       <= grant_d;
         cnt_q         <= cnt_d;
         lite_valid_q  <= lite_valid_d;
         lite_awaddr_q <= lite_awaddr_d;
         lite_wdata_q  <= lite_wdata_d;
         req_end_q     <= req_end_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign lite_valid  = lite_valid_q;
   assign lite_awaddr = lite_awaddr_q;
   assign lite_wdata  = lite_wdata_q;
   assign req0_end    = req_end_q[0];
   assign req1_end    = req_end_q[1];
   assign ovf_err     = slot_ovf;
   assign timeout_err = timeout_err_q;

endmodule

// File: doc/dma_lite_arb.md
DMA_LITE_ARB -- requirements
Module: dma_lite_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, is the number of WAIT-state cycles without lite_end before a transaction is abandoned.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  one-cycle pulse; requester 0 (MM2S control) register-write request.
REQ-005 req0_awaddr  input  10  requester 0 register address, sampled with req0_valid.
REQ-006 req0_wdata  input  32  requester 0 write data, sampled with req0_valid.
REQ-007 req0_end  output  1  one-cycle pulse; requester 0 transaction finished (done or timed out).
REQ-008 req1_valid / req1_awaddr / req1_wdata / req1_end  same widths and directions as requester 0; requester 1 (S2MM control).
REQ-009 lite_valid  output  1  one-cycle pulse to the shared AXI-Lite write engine.
REQ-010 lite_awaddr  output  10  granted address; held stable from lite_valid until the transaction ends.
REQ-011 lite_wdata  output  32  granted data; held stable like lite_awaddr.
REQ-012 lite_end  input  1  one-cycle pulse from the write engine; write response received.
REQ-013 ovf_err  output  2  sticky per-requester flag; request dropped because that slot was occupied.
REQ-014 timeout_err  output  1  sticky flag; at least one transaction timed out.

Function
REQ-015 Each requester has a one-entry slot: req valid pulse captures addr/data and sets pending on the next edge.
REQ-016 A valid pulse while that slot is pending SHALL be dropped, slot contents unchanged, ovf_err[n] set.
REQ-017 A valid pulse in the same cycle the slot clears (end cycle) SHALL be accepted, not flagged.
REQ-018 FSM states IDLE, ISSUE, WAIT; reset state IDLE.
REQ-019 IDLE -> ISSUE when any slot is pending; grant chosen by round-robin pointer rr (0 after reset): pending[rr] wins, else the other.
REQ-020 ISSUE lasts exactly one cycle with lite_valid=1 and lite_awaddr/lite_wdata from the granted slot; then WAIT.
REQ-021 lite_end is honoured only in WAIT; pulses in IDLE or ISSUE are ignored.
REQ-022 WAIT + lite_end: next cycle reqN_end=1 for the granted requester, its pending clears, rr <= other requester, state IDLE.
REQ-023 WAIT cycle counter starts at 0 on entry; when it reaches TIMEOUT_CYCLES-1 without lite_end, behaviour equals REQ-022 plus timeout_err set.
REQ-024 lite_end and timeout in the same cycle: treated as normal completion; timeout_err unchanged.
REQ-025 Latency: req pulse at cycle 0 with idle arbiter -> lite_valid at cycle 2; lite_end at cycle k -> reqN_end at k+1; next ISSUE no earlier than k+2.
REQ-026 Simultaneous req0_valid and req1_valid: both captured, served in rr order back-to-back.
REQ-027 Counter width is ceil(log2(TIMEOUT_CYCLES)); no wrap occurs before the timeout compare.

Reset
REQ-028 rst SHALL clear: state IDLE, rr 0, both pending, counter, lite_valid, req0_end, req1_end, ovf_err, timeout_err, lite_awaddr and lite_wdata to 0.
REQ-029 rst asserted mid-transaction abandons it with no reqN_end pulse; lite_end after reset release in IDLE is ignored.

Structure
REQ-030 Package dma_lite_pkg holds the FSM state encoding, requester count (2), address width (10), data width (32).
REQ-031 Sub-module lite_req_slot (capture register, pending flag, overflow detect) is instantiated once per requester.

Verification
REQ-032 req0_valid addr 0x018 data 0x1000_0000, lite_end 5 cycles after lite_valid -> lite_valid at cycle 2 with 0x018/0x1000_0000, req0_end one cycle after lite_end.
REQ-033 req0 and req1 pulse same cycle after reset -> req0 issued first, req1 ISSUE two cycles after req0_end-producing lite_end; rr then 0.
REQ-034 req1 pulsed twice while pending (addr 0x048 then 0x058) -> only 0x048 issued, ovf_err=2'b10.
REQ-035 TIMEOUT_CYCLES=16, no lite_end -> req0_end 16 cycles after WAIT entry, timeout_err=1, next pending request then issues.
REQ-036 rst during WAIT, then lite_end -> no reqN_end, all outputs 0, state IDLE.
REQ-037 lite_end pulsed during ISSUE -> ignored; transaction completes only on a later lite_end in WAIT.
